// File: rtl/sprite_fetch_ctrl_pkg.sv
// Shared definitions for the sprite fetch controller: default geometry,
// animation state encodings and width helpers.
package sprite_fetch_ctrl_pkg;

    localparam int DATA_WIDTH_D = 12;
    localparam int ADDR_WIDTH_D = 15;
    localparam int SPR_W_D      = 64;
    localparam int SPR_H_D      = 64;
    localparam int NUM_FRAMES_D = 8;
    localparam int FRAME_DIV_D  = 6;
    localparam int PIX_W_D      = 10;
    localparam logic [DATA_WIDTH_D-1:0] TRANSP_D = 12'hF0F;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } anim_state_e;

    // Bits needed to index n items, never less than one.
    function automatic int clog2_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int FRAME_W_D = clog2_min1(NUM_FRAMES_D);

endpackage

// File: rtl/sprite_fetch_ctrl_if.sv
// Bundle of DTG timing, sprite control, sprite RAM read port and colorizer
// outputs. The fetch controller uses the slave view, its environment the master.
interface sprite_fetch_ctrl_if
    import sprite_fetch_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_D,
    parameter int ADDR_WIDTH = ADDR_WIDTH_D,
    parameter int PIX_W      = PIX_W_D,
    parameter int FRAME_W    = FRAME_W_D
);
    logic [PIX_W-1:0]      pix_row;
    logic [PIX_W-1:0]      pix_col;
    logic                  video_on;
    logic                  frame_tick;
    logic [PIX_W-1:0]      spr_x;
    logic [PIX_W-1:0]      spr_y;
    logic [1:0]            spr_flip;
    logic                  anim_en;
    logic                  anim_once;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic [DATA_WIDTH-1:0] rd_data;
    logic [DATA_WIDTH-1:0] pix_color;
    logic                  pix_valid;
    logic [FRAME_W-1:0]    cur_frame;
    logic                  anim_done;

    modport master (
        output pix_row, pix_col, video_on, frame_tick,
        output spr_x, spr_y, spr_flip, anim_en, anim_once,
        output rd_data,
        input  rd_addr, pix_color, pix_valid, cur_frame, anim_done
    );

    modport slave (
        input  pix_row, pix_col, video_on, frame_tick,
        input  spr_x, spr_y, spr_flip, anim_en, anim_once,
        input  rd_data,
        output rd_addr, pix_color, pix_valid, cur_frame, anim_done
    );

endinterface

// File: rtl/sprite_fetch_ctrl_anim_fsm.sv
// Animation sequencer: counts vertical-blank ticks and steps the displayed
// frame, looping or parking on the last frame in once mode.
module sprite_fetch_ctrl_anim_fsm
    import sprite_fetch_ctrl_pkg::*;
#(
    parameter int NUM_FRAMES = NUM_FRAMES_D,
    parameter int FRAME_DIV  = FRAME_DIV_D,
    parameter int FRAME_W    = FRAME_W_D
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               frame_tick,
    input  logic               anim_en,
    input  logic               anim_once,
    output logic [FRAME_W-1:0] cur_frame,
    output logic               anim_done
);

    localparam int DIV_W = clog2_min1(FRAME_DIV);
    localparam logic [DIV_W-1:0]   DIV_LAST    = DIV_W'(FRAME_DIV - 1);
    localparam logic [FRAME_W-1:0] FRAME_LAST  = FRAME_W'(NUM_FRAMES - 1);
    localparam logic [FRAME_W-1:0] FRAME_PENUL = FRAME_W'(NUM_FRAMES - 2);

    anim_state_e        state_r, state_n_s;
    logic [DIV_W-1:0]   div_r, div_n_s;
    logic [FRAME_W-1:0] frame_r, frame_n_s;
    logic               done_r, done_n_s;

    // State, divider, frame and done flag registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= ST_IDLE;
            div_r   <= '0;
            frame_r <= '0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_n_s;
            div_r   <= div_n_s;
            frame_r <= frame_n_s;
            done_r  <= done_n_s;
        end
    end

    // Next-state logic; losing anim_en takes priority over a coincident tick
    always_comb begin
        state_n_s = state_r;
        div_n_s   = div_r;
        frame_n_s = frame_r;
        case (state_r)
            ST_IDLE: begin
                div_n_s = '0;
                if (anim_en) begin
                    state_n_s = ST_RUN;
                end else begin
                    state_n_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (!anim_en) begin
                    state_n_s = ST_IDLE;
                    div_n_s   = '0;
                end else if (frame_tick && (div_r == DIV_LAST)) begin
                    div_n_s = '0;
                    if (frame_r == FRAME_LAST) begin
                        if (anim_once) begin
                            state_n_s = ST_DONE;
                        end else begin
                            frame_n_s = '0;
                        end
                    end else begin
                        frame_n_s = frame_r + 1'b1;
                        // Once mode parks as soon as it lands on the last frame
                        if (anim_once && (frame_r == FRAME_PENUL)) begin
                            state_n_s = ST_DONE;
                        end else begin
                            state_n_s = ST_RUN;
                        end
                    end
                end else if (frame_tick) begin
                    div_n_s = div_r + 1'b1;
                end else begin
                    state_n_s = ST_RUN;
                end
            end
            ST_DONE: begin
                if (!anim_en || !anim_once) begin
                    state_n_s = ST_IDLE;
                end else begin
                    state_n_s = ST_DONE;
                end
            end
            default: begin
                state_n_s = ST_IDLE;
                div_n_s   = '0;
                frame_n_s = '0;
            end
        endcase
        done_n_s = (state_n_s == ST_DONE);
    end

    assign cur_frame = frame_r;
    assign anim_done = done_r;

endmodule

// File: rtl/sprite_fetch_ctrl.sv
// Sprite fetch controller: maps DTG row/col to a sprite-sheet address,
// absorbs the RAM read latency and emits a registered colour and opaque flag.
module sprite_fetch_ctrl
    import sprite_fetch_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_D,
    parameter int ADDR_WIDTH = ADDR_WIDTH_D,
    parameter int SPR_W      = SPR_W_D,
    parameter int SPR_H      = SPR_H_D,
    parameter int NUM_FRAMES = NUM_FRAMES_D,
    parameter int FRAME_DIV  = FRAME_DIV_D,
    parameter int PIX_W      = PIX_W_D,
    parameter logic [DATA_WIDTH-1:0] TRANSP = TRANSP_D
) (
    input  logic                clk,
    input  logic                reset,
    sprite_fetch_ctrl_if.slave  bus
);

    localparam int LX_W    = clog2_min1(SPR_W);
    localparam int LY_W    = clog2_min1(SPR_H);
    localparam int FRAME_W = clog2_min1(NUM_FRAMES);

    logic [PIX_W-1:0]      sx_r, sy_r;
    logic [1:0]            flip_r;
    logic [PIX_W:0]        dx_s, dy_s;
    logic [LX_W-1:0]       lx_s;
    logic [LY_W-1:0]       ly_s;
    logic                  hit_s;
    logic [ADDR_WIDTH-1:0] addr_s;
    logic [FRAME_W-1:0]    cur_frame_s;
    logic                  anim_done_s;
    logic [ADDR_WIDTH-1:0] rd_addr_r;
    logic                  hit1_r, hit2_r;
    logic [DATA_WIDTH-1:0] pix_color_r;
    logic                  pix_valid_r;

    sprite_fetch_ctrl_anim_fsm #(
        .NUM_FRAMES (NUM_FRAMES),
        .FRAME_DIV  (FRAME_DIV),
        .FRAME_W    (FRAME_W)
    ) u_anim (
        .clk        (clk),
        .reset      (reset),
        .frame_tick (bus.frame_tick),
        .anim_en    (bus.anim_en),
        .anim_once  (bus.anim_once),
        .cur_frame  (cur_frame_s),
        .anim_done  (anim_done_s)
    );

    // Placement shadows change only at vertical blank so a frame never tears
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sx_r   <= '0;
            sy_r   <= '0;
            flip_r <= 2'b00;
        end else if (bus.frame_tick) begin
            sx_r   <= bus.spr_x;
            sy_r   <= bus.spr_y;
            flip_r <= bus.spr_flip;
        end
    end

    // Hit test and sheet address; the extra top bit flags a negative offset
    always_comb begin
        dx_s = {1'b0, bus.pix_col} - {1'b0, sx_r};
        dy_s = {1'b0, bus.pix_row} - {1'b0, sy_r};
        hit_s = bus.video_on
              && !dx_s[PIX_W] && (dx_s[PIX_W-1:0] < PIX_W'(SPR_W))
              && !dy_s[PIX_W] && (dy_s[PIX_W-1:0] < PIX_W'(SPR_H));
        // Sprite sides are powers of two, so SIZE-1-n is just ~n
        if (flip_r[0]) begin
            lx_s = ~dx_s[LX_W-1:0];
        end else begin
            lx_s = dx_s[LX_W-1:0];
        end
        if (flip_r[1]) begin
            ly_s = ~dy_s[LY_W-1:0];
        end else begin
            ly_s = dy_s[LY_W-1:0];
        end
        addr_s = ADDR_WIDTH'({cur_frame_s, ly_s, lx_s});
    end

    // Address stage plus two-deep hit pipeline aligned with the RAM latency
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_addr_r   <= '0;
            hit1_r      <= 1'b0;
            hit2_r      <= 1'b0;
            pix_color_r <= '0;
            pix_valid_r <= 1'b0;
        end else begin
            if (hit_s) begin
                rd_addr_r <= addr_s;
            end
            hit1_r      <= hit_s;
            hit2_r      <= hit1_r;
            pix_color_r <= bus.rd_data;
            pix_valid_r <= hit2_r && (bus.rd_data != TRANSP);
        end
    end

    assign bus.rd_addr   = rd_addr_r;
    assign bus.pix_color = pix_color_r;
    assign bus.pix_valid = pix_valid_r;
    assign bus.cur_frame = cur_frame_s;
    assign bus.anim_done = anim_done_s;

endmodule

// File: tb/tb_sprite_fetch_ctrl.sv
// Scoreboard bench for sprite_fetch_ctrl: pixel stimulus queues expected
// address and colour; a negedge monitor pops and compares on pipeline arrival.
module tb_sprite_fetch_ctrl;

    typedef struct {
        logic        chk;
        logic [14:0] addr;
        string       name;
    } addr_exp_t;

    typedef struct {
        logic        chk_color;
        logic        valid;
        logic [11:0] color;
        string       name;
    } pix_exp_t;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    logic iss   = 1'b0;
    logic d1    = 1'b0;
    logic d2    = 1'b0;
    logic d3    = 1'b0;
    int   checks = 0;
    int   errors = 0;
    addr_exp_t addr_q[$];
    pix_exp_t  pix_q[$];

    sprite_fetch_ctrl_if #(
        .DATA_WIDTH (12),
        .ADDR_WIDTH (15),
        .PIX_W      (10),
        .FRAME_W    (3)
    ) bus ();

    sprite_fetch_ctrl dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Sprite RAM stand-in: q one clock after the address, word = addr[11:0] ^ 0x0F0
    always @(posedge clk) bus.rd_data <= bus.rd_addr[11:0] ^ 12'h0F0;

    // Bench-side latency model: address after 1 clk, colour after 3 clk
    always @(posedge clk) begin
        d1 <= iss;
        d2 <= d1;
        d3 <= d2;
    end

    task automatic check_val(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", name, got, exp);
        end
    endtask

    // Monitor: compare whatever the pipeline presents against the queued expectation
    always @(negedge clk) begin
        addr_exp_t ae;
        pix_exp_t  pe;
        if (d1) begin
            if (addr_q.size() == 0) begin
                check_val("addr_queue_underflow", 32'd1, 32'd0);
            end else begin
                ae = addr_q.pop_front();
                if (ae.chk) check_val({ae.name, "_rd_addr"}, 32'(bus.rd_addr), 32'(ae.addr));
            end
        end
        if (d3) begin
            if (pix_q.size() == 0) begin
                check_val("pix_queue_underflow", 32'd1, 32'd0);
            end else begin
                pe = pix_q.pop_front();
                check_val({pe.name, "_pix_valid"}, 32'(bus.pix_valid), 32'(pe.valid));
                if (pe.chk_color) check_val({pe.name, "_pix_color"}, 32'(bus.pix_color), 32'(pe.color));
            end
        end
    end

    task automatic pix(input string name, input int row, input int col, input logic vid,
                       input int ea, input logic ev, input logic cc, input int ec);
        bus.pix_row  = 10'(row);
        bus.pix_col  = 10'(col);
        bus.video_on = vid;
        iss = 1'b1;
        addr_q.push_back('{1'b1, 15'(ea), name});
        pix_q.push_back('{cc, ev, 12'(ec), name});
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        iss = 1'b0;
        bus.video_on = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic tick();
        iss = 1'b0;
        bus.frame_tick = 1'b1;
        @(posedge clk);
        #1;
        bus.frame_tick = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.pix_row = 10'd0;   bus.pix_col = 10'd0;   bus.video_on = 1'b0;
        bus.frame_tick = 1'b0; bus.spr_x = 10'd0;     bus.spr_y = 10'd0;
        bus.spr_flip = 2'b00;  bus.anim_en = 1'b0;    bus.anim_once = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_val("reset_rd_addr",   32'(bus.rd_addr),   32'd0);
        check_val("reset_pix_color", 32'(bus.pix_color), 32'd0);
        check_val("reset_pix_valid", 32'(bus.pix_valid), 32'd0);
        check_val("reset_cur_frame", 32'(bus.cur_frame), 32'd0);
        check_val("reset_anim_done", 32'(bus.anim_done), 32'd0);
        reset = 1'b0;

        // Basic hits, window edges, misses with rd_addr held
        bus.spr_x = 10'd100; bus.spr_y = 10'd50; bus.spr_flip = 2'b00;
        tick();
        pix("origin",      50,  100, 1'b1, 0,    1'b1, 1'b1, 12'h0F0);
        pix("right_edge",  50,  163, 1'b1, 63,   1'b1, 1'b1, 12'h0CF);
        pix("past_right",  50,  164, 1'b1, 63,   1'b0, 1'b0, 0);
        pix("above",       49,  100, 1'b1, 63,   1'b0, 1'b0, 0);
        pix("inner",       51,  101, 1'b1, 65,   1'b1, 1'b1, 12'h0B1);
        pix("bottom_edge", 113, 100, 1'b1, 4032, 1'b1, 1'b1, 12'hF30);
        pix("below",       114, 100, 1'b1, 4032, 1'b0, 1'b0, 0);
        pix("left",        50,  99,  1'b1, 4032, 1'b0, 1'b0, 0);
        pix("video_off",   50,  100, 1'b0, 4032, 1'b0, 1'b0, 0);
        idle(4);

        // Placement change without a tick must not reach the pixel math
        bus.spr_x = 10'd300;
        pix("no_tear_hit",  50, 100, 1'b1, 0, 1'b1, 1'b1, 12'h0F0);
        pix("no_tear_miss", 50, 300, 1'b1, 0, 1'b0, 1'b0, 0);
        idle(4);

        // Mirroring, transparent key and right-edge clipping
        bus.spr_x = 10'd100; bus.spr_flip = 2'b11;
        tick();
        pix("flip_xy_transp", 50, 100, 1'b1, 4095, 1'b0, 1'b0, 0);
        pix("flip_xy",        50, 101, 1'b1, 4094, 1'b1, 1'b1, 12'hF0E);
        bus.spr_flip = 2'b01;
        tick();
        pix("flip_x",         51, 100, 1'b1, 127,  1'b1, 1'b1, 12'h08F);
        bus.spr_x = 10'd1000;
        tick();
        pix("clip_right",     50, 1020, 1'b1, 43,  1'b1, 1'b1, 12'h0DB);
        pix("clip_left_miss", 50, 999,  1'b1, 43,  1'b0, 1'b0, 0);
        idle(4);

        // Looping animation, six ticks per step
        bus.spr_x = 10'd100; bus.spr_flip = 2'b00;
        bus.anim_en = 1'b1; bus.anim_once = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        for (int k = 1; k <= 48; k++) begin
            tick();
            check_val($sformatf("loop_frame_t%0d", k), 32'(bus.cur_frame), 32'((k / 6) % 8));
        end
        check_val("loop_done_low", 32'(bus.anim_done), 32'd0);
        for (int k = 1; k <= 10; k++) begin
            if (k == 10) bus.anim_en = 1'b0;
            tick();
        end
        check_val("hold_at_drop", 32'(bus.cur_frame), 32'd1);
        repeat (6) tick();
        check_val("hold_later", 32'(bus.cur_frame), 32'd1);
        pix("frame1_addr", 50, 100, 1'b1, 4096, 1'b1, 1'b1, 12'h0F0);
        idle(4);

        // Asynchronous reset with a visible pixel in flight
        bus.pix_row = 10'd50; bus.pix_col = 10'd100; bus.video_on = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check_val("pre_reset_valid", 32'(bus.pix_valid), 32'd1);
        check_val("pre_reset_addr",  32'(bus.rd_addr),   32'd4096);
        #2;
        reset = 1'b1;
        #1;
        check_val("async_rd_addr",   32'(bus.rd_addr),   32'd0);
        check_val("async_pix_color", 32'(bus.pix_color), 32'd0);
        check_val("async_pix_valid", 32'(bus.pix_valid), 32'd0);
        check_val("async_cur_frame", 32'(bus.cur_frame), 32'd0);
        check_val("async_anim_done", 32'(bus.anim_done), 32'd0);
        bus.video_on = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        pix("first_after_reset", 0, 0, 1'b1, 0, 1'b1, 1'b1, 12'h0F0);
        idle(4);

        // Once mode parks on the last frame
        bus.anim_en = 1'b1; bus.anim_once = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        repeat (41) tick();
        check_val("once_t41_frame", 32'(bus.cur_frame), 32'd6);
        check_val("once_t41_done",  32'(bus.anim_done), 32'd0);
        tick();
        check_val("once_t42_frame", 32'(bus.cur_frame), 32'd7);
        check_val("once_t42_done",  32'(bus.anim_done), 32'd1);
        repeat (5) tick();
        check_val("once_parked_frame", 32'(bus.cur_frame), 32'd7);
        check_val("once_parked_done",  32'(bus.anim_done), 32'd1);
        bus.anim_once = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_val("once_clear_done",  32'(bus.anim_done), 32'd0);
        check_val("once_clear_frame", 32'(bus.cur_frame), 32'd7);

        idle(4);
        check_val("addr_queue_drained", 32'(addr_q.size()), 32'd0);
        check_val("pix_queue_drained",  32'(pix_q.size()),  32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
